// File: rtl/count_times_sched_if.sv
// Request/stream/completion bundle for count_times_sched.
// The slave modport is the scheduler; the master modport is the requester/consumer side.
interface count_times_sched_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CW      = 8
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*CW-1:0] req_target;
  logic [NUM_REQ-1:0]    req_accept;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_last;
  logic                  abort;
  logic [NUM_REQ-1:0]    done;
  logic                  done_aborted;

  modport master (
    output req_valid, req_target, out_ready, abort,
    input  req_accept, out_valid, out_data, out_id, out_last, done, done_aborted
  );

  modport slave (
    input  req_valid, req_target, out_ready, abort,
    output req_accept, out_valid, out_data, out_id, out_last, done, done_aborted
  );
endinterface

// File: rtl/count_times_sched.sv
// Round-robin scheduler sharing one staircase generator (0,1,2,2,3,3,3,...) among requesters.
// Define COUNT_TIMES_SCHED_STATS_EN to build the saturating completed-run counter.
module count_times_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CW      = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  count_times_sched_if.slave   bus,
  output logic                 busy_o,
  output logic [15:0]          stat_runs_o
);
  localparam int unsigned IDW = $clog2(NUM_REQ);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]     id_q, id_d;
  logic [CW-1:0]      target_q, target_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [CW-1:0]      rep_q, rep_d;
  logic [NUM_REQ-1:0] done_q, done_d;
  logic               done_aborted_q, done_aborted_d;

  logic               grant_found;
  logic [IDW-1:0]     grant_idx;
  logic [IDW-1:0]     scan_idx;
  logic [CW-1:0]      tgt_max, cnt_max;
  logic               last, hs;

  // First pending request at or after rr_ptr, with wrap.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    scan_idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      scan_idx = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
      if (!grant_found && bus.req_valid[scan_idx]) begin
        grant_found = 1'b1;
        grant_idx   = scan_idx;
      end
    end
  end

  assign tgt_max = (target_q == '0) ? CW'(1) : target_q;
  assign cnt_max = (cnt_q == '0) ? CW'(1) : cnt_q;
  assign last    = (cnt_q == target_q) && (rep_q == tgt_max);
  assign hs      = (state_q == StRun) && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StIdle;
      rr_ptr_q       <= '0;
      id_q           <= '0;
      target_q       <= '0;
      cnt_q          <= '0;
      rep_q          <= '0;
      done_q         <= '0;
      done_aborted_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      id_q           <= id_d;
      target_q       <= target_d;
      cnt_q          <= cnt_d;
      rep_q          <= rep_d;
      done_q         <= done_d;
      done_aborted_q <= done_aborted_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    id_d           = id_q;
    target_d       = target_q;
    cnt_d          = cnt_q;
    rep_d          = rep_q;
    done_d         = '0;
    done_aborted_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          state_d  = StRun;
          target_d = bus.req_target[32'(grant_idx)*CW +: CW];
          id_d     = grant_idx;
          cnt_d    = '0;
          rep_d    = CW'(1);
          rr_ptr_d = IDW'((32'(grant_idx) + 1) % NUM_REQ);
        end
      end
      StRun: begin
        // Completion of the last beat takes priority over a same-cycle abort.
        if (hs && last) begin
          state_d      = StIdle;
          done_d[id_q] = 1'b1;
        end else if (bus.abort) begin
          state_d        = StIdle;
          done_d[id_q]   = 1'b1;
          done_aborted_d = 1'b1;
        end else if (hs) begin
          if (rep_q >= cnt_max) begin
            cnt_d = cnt_q + CW'(1);
            rep_d = CW'(1);
          end else begin
            rep_d = rep_q + CW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.req_accept   = '0;
    bus.out_valid    = 1'b0;
    bus.out_data     = '0;
    bus.out_id       = '0;
    bus.out_last     = 1'b0;
    bus.done         = done_q;
    bus.done_aborted = done_aborted_q;
    busy_o           = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_found && !rst) bus.req_accept[grant_idx] = 1'b1;
      end
      StRun: begin
        bus.out_valid = 1'b1;
        bus.out_data  = cnt_q;
        bus.out_id    = id_q;
        bus.out_last  = last;
        busy_o        = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef COUNT_TIMES_SCHED_STATS_EN
  logic [15:0] stat_runs_q, stat_runs_d;
  logic        run_done;

  assign run_done = hs && last;

  always_comb begin
    stat_runs_d = stat_runs_q;
    if (run_done && stat_runs_q != 16'hFFFF) stat_runs_d = stat_runs_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_runs_q <= '0;
    else     stat_runs_q <= stat_runs_d;
  end

  assign stat_runs_o = stat_runs_q;
`else
  assign stat_runs_o = '0;
`endif

endmodule

// File: tb/tb_count_times_sched.sv
// Scoreboard bench for count_times_sched: expected beats/completions queued at stimulus time.
module tb_count_times_sched;
  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CW      = 8;
  localparam int unsigned IDW     = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [15:0] stat_runs;

  count_times_sched_if #(.NUM_REQ(NUM_REQ), .CW(CW)) bus ();

  count_times_sched #(.NUM_REQ(NUM_REQ), .CW(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy_o      (busy),
    .stat_runs_o (stat_runs)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0]  data;
    logic [IDW-1:0] id;
    logic           last;
  } beat_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic           aborted;
  } done_t;

  beat_t beat_q[$];
  done_t done_q[$];
  int    n_total  = 0;
  int    n_bad    = 0;
  int    done_cnt = 0;
  int    hs_cnt   = 0;
  int    exp_runs = 0;
  bit    gap_en   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_stat();
`ifdef COUNT_TIMES_SCHED_STATS_EN
    return (exp_runs > 65535) ? 32'd65535 : 32'(exp_runs);
`else
    return 32'd0;
`endif
  endfunction

  // Staircase model: value 0 once, each k>=1 k times; limit<0 means the whole run.
  function automatic void push_beats(input int id, input int t, input int limit);
    int n = 0;
    for (int k = 0; k <= t; k++) begin
      int reps = (k == 0) ? 1 : k;
      for (int r = 1; r <= reps; r++) begin
        if (limit >= 0 && n >= limit) return;
        beat_q.push_back({CW'(k), IDW'(id), (k == t) && (r == reps)});
        n++;
      end
    end
  endfunction

  // Output monitor, sampled on the falling edge.
  beat_t cur, prev, exp_b;
  done_t exp_d;
  bit    prev_stall = 1'b0;
  bit    prev_valid = 1'b0;
  bit    gap_armed  = 1'b0;
  int    idle_run   = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
      prev_valid = 1'b0;
      idle_run   = 0;
    end else begin
      cur = {bus.out_data, bus.out_id, bus.out_last};
      if (prev_stall) begin
        check_eq("hold_valid", 32'(bus.out_valid), 32'd1);
        check_eq("hold_beat", 32'(cur), 32'(prev));
      end
      if (bus.out_valid && !prev_valid) begin
        if (gap_en && gap_armed) check_eq("run_gap", 32'(idle_run), 32'd1);
        gap_armed = gap_en;
      end
      idle_run = bus.out_valid ? 0 : idle_run + 1;
      if (bus.out_valid && bus.out_ready) begin
        hs_cnt++;
        check_eq("beat_expected", 32'(beat_q.size() != 0), 32'd1);
        if (beat_q.size() != 0) begin
          exp_b = beat_q.pop_front();
          check_eq("beat", 32'(cur), 32'(exp_b));
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_valid = bus.out_valid;
      prev       = cur;
      if (bus.done != '0) begin
        done_cnt++;
        check_eq("done_expected", 32'(done_q.size() != 0), 32'd1);
        if (done_q.size() != 0) begin
          exp_d = done_q.pop_front();
          check_eq("done_vec", 32'(bus.done), 32'd1 << exp_d.id);
          check_eq("done_aborted", 32'(bus.done_aborted), 32'(exp_d.aborted));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(input int target_cnt, input int budget);
    int n = 0;
    while (done_cnt < target_cnt && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_eq("done_seen", 32'(done_cnt >= target_cnt), 32'd1);
  endtask

  task automatic run_one(input int id, input int t, input int budget);
    int start = done_cnt;
    push_beats(id, t, -1);
    done_q.push_back({IDW'(id), 1'b0});
    exp_runs++;
    bus.req_target[id*CW +: CW] = CW'(t);
    bus.req_valid = 4'b0001 << id;
    #1;
    check_eq("accept", 32'(bus.req_accept), 32'd1 << id);
    tick();
    bus.req_valid = '0;
    wait_done(start + 1, budget);
    tick();
    check_eq("stat_runs", 32'(stat_runs), exp_stat());
  endtask

  // All requesters pending; grants expected in rotation starting from first.
  task automatic rr_burst(input int first, input int n, input int t);
    int start = done_cnt;
    int acc = 0;
    int cyc = 0;
    for (int i = 0; i < n; i++) begin
      push_beats((first + i) % NUM_REQ, t, -1);
      done_q.push_back({IDW'((first + i) % NUM_REQ), 1'b0});
      bus.req_target[i % NUM_REQ * CW +: CW] = CW'(t);
    end
    exp_runs += n;
    bus.req_valid = '1;
    while (acc < n && cyc < 200) begin
      @(negedge clk);
      if (bus.req_accept != '0) begin
        check_eq("rr_grant", 32'(bus.req_accept), 32'd1 << ((first + acc) % NUM_REQ));
        acc++;
      end
      cyc++;
    end
    check_eq("rr_accepts", 32'(acc), 32'(n));
    tick();
    bus.req_valid = '0;
    wait_done(start + n, 200);
    tick();
  endtask

  initial begin
    int hs0, d0, cyc;
    rst            = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_target = '0;
    bus.out_ready  = 1'b0;
    bus.abort      = 1'b0;
    #12;
    check_eq("rst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_accept", 32'(bus.req_accept), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_stat", 32'(stat_runs), 32'd0);
    bus.req_valid = '0;
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // Four requesters, target 1: rotation 0,1,2,3,0 with one idle cycle between runs.
    bus.out_ready = 1'b1;
    gap_en = 1'b1;
    rr_burst(0, 5, 1);
    gap_en = 1'b0;
    check_eq("t3_stat", 32'(stat_runs), exp_stat());

    run_one(0, 3, 100);
    run_one(2, 0, 100);
    run_one(1, 255, 40000);

    // Stalled stream: ready pattern 1,0,0 repeating, target 4 is 11 beats.
    hs0 = hs_cnt;
    d0  = done_cnt;
    push_beats(1, 4, -1);
    done_q.push_back({IDW'(1), 1'b0});
    exp_runs++;
    bus.req_target[1*CW +: CW] = CW'(4);
    bus.req_valid = 4'b0010;
    cyc = 0;
    while (done_cnt == d0 && cyc < 200) begin
      bus.out_ready = (cyc % 3 == 0);
      tick();
      bus.req_valid = '0;
      cyc++;
    end
    check_eq("t4_done_seen", 32'(done_cnt != d0), 32'd1);
    check_eq("t4_beats", 32'(hs_cnt - hs0), 32'd11);
    bus.out_ready = 1'b1;
    tick();
    check_eq("t4_stat", 32'(stat_runs), exp_stat());

    // Abort on the 4th beat of a target-5 run.
    push_beats(3, 5, 4);
    done_q.push_back({IDW'(3), 1'b1});
    bus.req_target[3*CW +: CW] = CW'(5);
    bus.req_valid = 4'b1000;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    check_eq("t5_beat4_valid", 32'(bus.out_valid), 32'd1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    check_eq("t5_valid_low", 32'(bus.out_valid), 32'd0);
    check_eq("t5_done", 32'(bus.done), 32'b1000);
    check_eq("t5_aborted", 32'(bus.done_aborted), 32'd1);
    check_eq("t5_stat", 32'(stat_runs), exp_stat());
    tick();

    // Asynchronous reset mid-run (target 3, requester 2 so rr_ptr moves off 0).
    push_beats(2, 3, 3);
    bus.req_target[2*CW +: CW] = CW'(3);
    bus.req_valid = 4'b0100;
    tick();
    bus.req_valid = '0;
    repeat (3) tick();
    bus.out_ready = 1'b0;
    d0 = done_cnt;
    #2 rst = 1'b1;
    #1;
    check_eq("mrst_valid", 32'(bus.out_valid), 32'd0);
    check_eq("mrst_busy", 32'(busy), 32'd0);
    check_eq("mrst_data", 32'(bus.out_data), 32'd0);
    check_eq("mrst_last", 32'(bus.out_last), 32'd0);
    check_eq("mrst_done", 32'(bus.done), 32'd0);
    exp_runs = 0;
    @(posedge clk);
    #3 rst = 1'b0;
    repeat (3) tick();
    check_eq("mrst_no_done", 32'(done_cnt), 32'(d0));
    check_eq("mrst_stat", 32'(stat_runs), exp_stat());

    // rr_ptr back at 0: rotation restarts at requester 0; three completions follow.
    bus.out_ready = 1'b1;
    rr_burst(0, 3, 1);
    check_eq("stat_after_3", 32'(stat_runs), exp_stat());

    check_eq("beat_q_empty", 32'(beat_q.size()), 32'd0);
    check_eq("done_q_empty", 32'(done_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
